// File: rtl/posit_pack.sv
// posit_pack: two-stage posit encoder fed by the adder normalise stage.
// Stage 1 decodes the regime run and assembles the truncated body with
// guard/sticky; stage 2 rounds to nearest-even and applies the sign.
// Pipeline moves on a valid/ready handshake with full backpressure.
module posit_pack #(
    parameter int WIDTH = 7,
    parameter int EN    = 1,
    parameter int W_REG = $clog2(WIDTH),
    parameter int W_EXP = $clog2(WIDTH),
    parameter int W_MAN = WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sign,
    input  logic                    nar,
    input  logic [W_MAN-1:0]        mantissa,
    input  logic signed [W_REG-1:0] regime,
    input  logic signed [W_EXP-1:0] exponent,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_posit
);

    // Body excludes the sign bit.
    localparam int BW  = WIDTH - 1;
    // Exponent and mantissa bits following the regime terminator.
    localparam int TW  = EN + W_MAN;
    // Two seed bits, tail, and zero padding so no tail bit is shifted out
    // for any non-saturating regime; everything below the body feeds
    // guard/sticky.
    localparam int SW  = 2 + TW + WIDTH;
    // Regime magnitude at which the run fills the body completely.
    localparam int SAT = WIDTH - 2;

    logic               s2_load;
    logic               s1_load;

    logic [TW-1:0]      tail;
    logic [W_REG-1:0]   shamt;
    logic [SW-1:0]      stream;
    int                 k_val;
    logic [BW-1:0]      dec_body;
    logic               dec_guard;
    logic               dec_sticky;
    logic               dec_zero;
    logic               dec_sat_max;
    logic               dec_sat_min;

    logic               s1_valid_q,   s1_valid_d;
    logic [BW-1:0]      s1_body_q,    s1_body_d;
    logic               s1_guard_q,   s1_guard_d;
    logic               s1_sticky_q,  s1_sticky_d;
    logic               s1_sign_q,    s1_sign_d;
    logic               s1_zero_q,    s1_zero_d;
    logic               s1_nar_q,     s1_nar_d;
    logic               s1_sat_max_q, s1_sat_max_d;
    logic               s1_sat_min_q, s1_sat_min_d;

    logic               round_up;
    logic [BW-1:0]      rnd_body;
    logic [WIDTH-1:0]   rnd_word;

    logic               s2_valid_q,   s2_valid_d;
    logic [WIDTH-1:0]   s2_word_q,    s2_word_d;

    // Advance rules: s2 frees when empty or drained; s1 frees when empty or shifting.
    always_comb begin
        s2_load = !s2_valid_q || out_ready;
        s1_load = !s1_valid_q || s2_load;
    end

    assign in_ready  = s1_load;
    assign out_valid = s2_valid_q;
    assign out_posit = s2_word_q;

    // Regime run decode and body assembly. For k >= 0 an arithmetic shift of
    // "10,tail" by k replicates the leading one into k+1 ones; for k < 0 a
    // logical shift of "01,tail" by -k-1 (== ~k) yields -k zeros then the 1.
    always_comb begin
        k_val = {{(32-W_REG){regime[W_REG-1]}}, regime};
        tail  = {exponent[EN-1:0], mantissa};
        if (regime[W_REG-1]) begin
            shamt  = ~regime;
            stream = {2'b01, tail, {WIDTH{1'b0}}} >> shamt;
        end else begin
            shamt  = regime;
            stream = $signed({2'b10, tail, {WIDTH{1'b0}}}) >>> shamt;
        end
        dec_body    = stream[SW-1 -: BW];
        dec_guard   = stream[SW-1-BW];
        dec_sticky  = |stream[SW-2-BW:0];
        dec_zero    = (regime == {1'b1, {(W_REG-1){1'b0}}}) &&
                      (mantissa == '0) && (exponent == '0);
        dec_sat_max = (k_val >= SAT);
        dec_sat_min = (k_val < -SAT);
    end

    // Stage 1 next-state: capture decoded fields when s1 is free.
    always_comb begin
        s1_valid_d   = s1_load ? in_valid : s1_valid_q;
        s1_body_d    = s1_body_q;
        s1_guard_d   = s1_guard_q;
        s1_sticky_d  = s1_sticky_q;
        s1_sign_d    = s1_sign_q;
        s1_zero_d    = s1_zero_q;
        s1_nar_d     = s1_nar_q;
        s1_sat_max_d = s1_sat_max_q;
        s1_sat_min_d = s1_sat_min_q;
        if (s1_load && in_valid) begin
            s1_body_d    = dec_body;
            s1_guard_d   = dec_guard;
            s1_sticky_d  = dec_sticky;
            s1_sign_d    = sign;
            s1_zero_d    = dec_zero;
            s1_nar_d     = nar;
            s1_sat_max_d = dec_sat_max;
            s1_sat_min_d = dec_sat_min;
        end
    end

    // Round to nearest-even, clamp at maxpos/minpos, then apply special codes and sign.
    always_comb begin
        round_up = s1_guard_q && (s1_sticky_q || s1_body_q[0]);
        rnd_body = s1_body_q;
        if (s1_sat_max_q) begin
            rnd_body = '1;
        end else if (s1_sat_min_q) begin
            rnd_body = BW'(1);
        end else begin
            if (round_up && (s1_body_q != '1)) begin
                rnd_body = s1_body_q + BW'(1);
            end
            if (rnd_body == '0) begin
                rnd_body = BW'(1);
            end
        end
        rnd_word = {1'b0, rnd_body};
        if (s1_sign_q) begin
            rnd_word = ~rnd_word + WIDTH'(1);
        end
        if (s1_zero_q) begin
            rnd_word = '0;
        end
        if (s1_nar_q) begin
            rnd_word = {1'b1, {BW{1'b0}}};
        end
    end

    // Stage 2 next-state: output word holds while stalled.
    always_comb begin
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        s2_word_d  = (s2_load && s1_valid_q) ? rnd_word : s2_word_q;
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_body_q    <= '0;
            s1_guard_q   <= 1'b0;
            s1_sticky_q  <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_nar_q     <= 1'b0;
            s1_sat_max_q <= 1'b0;
            s1_sat_min_q <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_word_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_body_q    <= s1_body_d;
            s1_guard_q   <= s1_guard_d;
            s1_sticky_q  <= s1_sticky_d;
            s1_sign_q    <= s1_sign_d;
            s1_zero_q    <= s1_zero_d;
            s1_nar_q     <= s1_nar_d;
            s1_sat_max_q <= s1_sat_max_d;
            s1_sat_min_q <= s1_sat_min_d;
            s2_valid_q   <= s2_valid_d;
            s2_word_q    <= s2_word_d;
        end
    end

endmodule

// File: tb/tb_posit_pack.sv
// tb_posit_pack: scenario tasks for posit_pack (WIDTH=7, EN=1) with a
// bit-string reference encoder and an in-order scoreboard.
module tb_posit_pack;

    localparam int WIDTH = 7;
    localparam int EN    = 1;
    localparam int W_REG = 3;
    localparam int W_EXP = 3;
    localparam int W_MAN = 7;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic                    sign;
    logic                    nar;
    logic [W_MAN-1:0]        mantissa;
    logic signed [W_REG-1:0] regime;
    logic signed [W_EXP-1:0] exponent;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_posit;

    int n_checks;
    int n_errors;
    logic [6:0] sb_q[$];

    posit_pack #(
        .WIDTH(WIDTH), .EN(EN), .W_REG(W_REG), .W_EXP(W_EXP), .W_MAN(W_MAN)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign(sign), .nar(nar),
        .mantissa(mantissa), .regime(regime), .exponent(exponent),
        .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder: writes the posit bit string out as a list of bits,
    // cuts it at the body width and rounds on the remainder.
    function automatic logic [6:0] ref_posit(bit s, bit n, logic [6:0] m, int k, int e);
        bit bits[$];
        int body;
        int guard;
        int sticky;
        int word;
        if (n) return 7'h40;
        if (k == -(1 << (W_REG - 1)) && m == 0 && e == 0) return 7'h00;
        if (k >= WIDTH - 2) begin
            body = (1 << (WIDTH - 1)) - 1;
        end else if (k < -(WIDTH - 2)) begin
            body = 1;
        end else begin
            if (k >= 0) begin
                repeat (k + 1) bits.push_back(1'b1);
                bits.push_back(1'b0);
            end else begin
                repeat (-k) bits.push_back(1'b0);
                bits.push_back(1'b1);
            end
            bits.push_back(e[0]);
            for (int i = 6; i >= 0; i--) bits.push_back(m[i]);
            body = 0;
            for (int i = 0; i < WIDTH - 1; i++)
                body = body * 2 + ((i < bits.size()) ? int'(bits[i]) : 0);
            guard = (bits.size() > WIDTH - 1) ? int'(bits[WIDTH - 1]) : 0;
            sticky = 0;
            for (int i = WIDTH; i < bits.size(); i++) sticky = sticky | int'(bits[i]);
            if (guard != 0 && (sticky != 0 || (body % 2) == 1)) begin
                if (body != 63) body = body + 1;
            end
            if (body == 0) body = 1;
        end
        word = s ? ((128 - body) % 128) : body;
        return word[6:0];
    endfunction

    task automatic rand_fields(input bit allow_nar, output bit s, output bit n,
                               output logic [6:0] m, output int k, output int e);
        s = 1'($urandom_range(0, 1));
        n = allow_nar && ($urandom_range(0, 15) == 0);
        m = 7'($urandom);
        k = int'($urandom_range(0, 7)) - 4;
        e = int'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) begin
            k = -4; m = '0; e = 0;
        end
    endtask

    // One clock cycle: drive at the falling edge, observe 1ns later, then
    // let the rising edge happen. Reports what transfers that edge performs.
    task automatic step(input bit v, input bit r, input bit s, input bit n,
                        input logic [6:0] m, input int k, input int e,
                        output bit acc, output bit emit, output logic [6:0] pos,
                        output bit ov, output bit ir);
        @(negedge clk);
        in_valid  = v;
        out_ready = r;
        sign      = s;
        nar       = n;
        mantissa  = m;
        regime    = k[2:0];
        exponent  = e[2:0];
        #1;
        acc  = in_valid && in_ready;
        emit = out_valid && out_ready;
        pos  = out_posit;
        ov   = out_valid;
        ir   = in_ready;
        @(posedge clk);
    endtask

    // Sends one word into an empty pipe and waits for it; lat is the number
    // of edges from the accepting edge (inclusive) until out_valid is seen.
    task automatic send_one(input bit s, input bit n, input logic [6:0] m,
                            input int k, input int e,
                            output logic [6:0] res, output int lat);
        bit acc, emit, ov, ir;
        logic [6:0] pos;
        res = 'x;
        lat = -1;
        step(1, 1, s, n, m, k, e, acc, emit, pos, ov, ir);
        if (acc) begin
            for (int i = 1; i < 10; i++) begin
                step(0, 1, 0, 0, '0, 0, 0, acc, emit, pos, ov, ir);
                if (ov) begin
                    res = pos;
                    lat = i;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        sign = 1'b0; nar = 1'b0; mantissa = '0; regime = '0; exponent = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_checks++;
        if (out_posit !== 7'h00) begin
            n_errors++; $display("FAIL reset_out_posit got %h want 00", out_posit);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [6:0] res;
        int lat;
        send_one(0, 0, 7'b0000000, 0, 0, res, lat);
        n_checks++;
        if (res !== 7'h20) begin
            n_errors++; $display("FAIL basic_pos got %h want 20", res);
        end
        n_checks++;
        if (lat !== 2) begin
            n_errors++; $display("FAIL basic_pos_latency got %0d want 2", lat);
        end
        send_one(1, 0, 7'b0000000, 0, 0, res, lat);
        n_checks++;
        if (res !== 7'h60) begin
            n_errors++; $display("FAIL basic_neg got %h want 60", res);
        end
        n_checks++;
        if (lat !== 2) begin
            n_errors++; $display("FAIL basic_neg_latency got %0d want 2", lat);
        end
    endtask

    task automatic test_rounding();
        logic [6:0] m_tab[4] = '{7'b1010000, 7'b1011000, 7'b1001000, 7'b1001001};
        logic [6:0] x_tab[4] = '{7'h25, 7'h26, 7'h24, 7'h25};
        logic [6:0] res;
        int lat;
        for (int i = 0; i < 4; i++) begin
            send_one(0, 0, m_tab[i], 0, 0, res, lat);
            n_checks++;
            if (res !== x_tab[i]) begin
                n_errors++;
                $display("FAIL rounding m=%b got %h want %h", m_tab[i], res, x_tab[i]);
            end
        end
    endtask

    task automatic test_regime();
        logic [6:0] res;
        int lat;
        send_one(0, 0, 7'b0000000, 3, 1, res, lat);
        n_checks++;
        if (res !== 7'h3D) begin
            n_errors++; $display("FAIL regime_k3 got %h want 3d", res);
        end
        send_one(0, 0, 7'b0000000, -4, 1, res, lat);
        n_checks++;
        if (res !== 7'h03) begin
            n_errors++; $display("FAIL regime_km4 got %h want 03", res);
        end
        send_one(1, 0, 7'b0000000, -4, 0, res, lat);
        n_checks++;
        if (res !== 7'h00) begin
            n_errors++; $display("FAIL zero_code got %h want 00", res);
        end
        send_one(1, 1, 7'($urandom), int'($urandom_range(0, 7)) - 4,
                 int'($urandom_range(0, 1)), res, lat);
        n_checks++;
        if (res !== 7'h40) begin
            n_errors++; $display("FAIL nar got %h want 40", res);
        end
    endtask

    task automatic test_backpressure();
        bit ws[5], wn[5];
        logic [6:0] wm[5];
        int wk[5], we[5];
        logic [6:0] first_word, pos, want;
        bit acc, emit, ov, ir;
        int idx, cur, nemit, first_emit, last_emit, gaps;
        for (int i = 0; i < 5; i++) rand_fields(0, ws[i], wn[i], wm[i], wk[i], we[i]);
        first_word = ref_posit(ws[0], wn[0], wm[0], wk[0], we[0]);
        sb_q.delete();
        idx = 0; nemit = 0; first_emit = -1; last_emit = -1; gaps = 0;
        for (int c = 0; c < 30 && nemit < 5; c++) begin
            cur = (idx < 5) ? idx : 0;
            step(idx < 5, c >= 4, ws[cur], wn[cur], wm[cur], wk[cur], we[cur],
                 acc, emit, pos, ov, ir);
            if (c == 2 || c == 3) begin
                n_checks++;
                if (ir !== 1'b0 || idx !== 2) begin
                    n_errors++;
                    $display("FAIL bp_in_ready c=%0d in_ready %b accepted %0d want 0/2", c, ir, idx);
                end
                n_checks++;
                if (ov !== 1'b1 || pos !== first_word) begin
                    n_errors++;
                    $display("FAIL bp_hold c=%0d valid %b posit %h want 1/%h", c, ov, pos, first_word);
                end
            end
            if (acc) begin
                sb_q.push_back(ref_posit(ws[cur], wn[cur], wm[cur], wk[cur], we[cur]));
                idx++;
            end
            if (emit) begin
                want = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
                n_checks++;
                if (pos !== want) begin
                    n_errors++; $display("FAIL bp_word %0d got %h want %h", nemit, pos, want);
                end
                if (last_emit >= 0 && c != last_emit + 1) gaps++;
                if (first_emit < 0) first_emit = c;
                last_emit = c;
                nemit++;
            end
        end
        n_checks++;
        if (nemit !== 5 || gaps !== 0 || first_emit !== 4) begin
            n_errors++;
            $display("FAIL bp_stream emitted %0d gaps %0d first %0d want 5/0/4", nemit, gaps, first_emit);
        end
    endtask

    task automatic test_back_to_back();
        bit s, n, acc, emit, ov, ir;
        logic [6:0] m, pos, want;
        int k, e, idx, nemit, first_emit, last_emit, gaps, acc_by8;
        sb_q.delete();
        idx = 0; nemit = 0; first_emit = -1; last_emit = -1; gaps = 0; acc_by8 = 0;
        for (int c = 0; c < 30 && nemit < 8; c++) begin
            rand_fields(1, s, n, m, k, e);
            step(idx < 8, 1, s, n, m, k, e, acc, emit, pos, ov, ir);
            if (acc) begin
                sb_q.push_back(ref_posit(s, n, m, k, e));
                idx++;
            end
            if (c == 7) acc_by8 = idx;
            if (emit) begin
                want = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
                n_checks++;
                if (pos !== want) begin
                    n_errors++; $display("FAIL b2b_word %0d got %h want %h", nemit, pos, want);
                end
                if (last_emit >= 0 && c != last_emit + 1) gaps++;
                if (first_emit < 0) first_emit = c;
                last_emit = c;
                nemit++;
            end
        end
        n_checks++;
        if (acc_by8 !== 8 || nemit !== 8 || gaps !== 0 || first_emit !== 2) begin
            n_errors++;
            $display("FAIL b2b_stream acc %0d emitted %0d gaps %0d first %0d want 8/8/0/2",
                     acc_by8, nemit, gaps, first_emit);
        end
    endtask

    task automatic test_random();
        bit s, n, acc, emit, ov, ir, v, r;
        logic [6:0] m, pos, want;
        int k, e, nemit, nacc;
        sb_q.delete();
        nemit = 0; nacc = 0;
        for (int c = 0; c < 340; c++) begin
            rand_fields(1, s, n, m, k, e);
            v = (c < 300) && ($urandom_range(0, 9) < 7);
            r = (c >= 300) || ($urandom_range(0, 9) < 7);
            step(v, r, s, n, m, k, e, acc, emit, pos, ov, ir);
            if (acc) begin
                sb_q.push_back(ref_posit(s, n, m, k, e));
                nacc++;
            end
            if (emit) begin
                want = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
                n_checks++;
                if (pos !== want) begin
                    n_errors++; $display("FAIL random_word %0d got %h want %h", nemit, pos, want);
                end
                nemit++;
            end
        end
        n_checks++;
        if (nemit !== nacc || sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL random_drain emitted %0d accepted %0d", nemit, nacc);
        end
    endtask

    task automatic test_reset_mid();
        bit s, n, acc, emit, ov, ir;
        logic [6:0] m, pos;
        int k, e, nacc, stale;
        nacc = 0; stale = 0;
        for (int i = 0; i < 2; i++) begin
            rand_fields(0, s, n, m, k, e);
            step(1, 0, s, n, m, k, e, acc, emit, pos, ov, ir);
            if (acc) nacc++;
        end
        step(0, 0, 0, 0, '0, 0, 0, acc, emit, pos, ov, ir);
        n_checks++;
        if (nacc !== 2 || ov !== 1'b1 || ir !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_fill accepted %0d valid %b ready %b want 2/1/0", nacc, ov, ir);
        end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_posit !== 7'h00 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_state valid %b posit %h ready %b want 0/00/1",
                     out_valid, out_posit, in_ready);
        end
        for (int c = 0; c < 6; c++) begin
            step(0, 1, 0, 0, '0, 0, 0, acc, emit, pos, ov, ir);
            if (ov) stale++;
        end
        n_checks++;
        if (stale !== 0) begin
            n_errors++; $display("FAIL rstmid_stale got %0d stale cycles want 0", stale);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_basic();
        test_rounding();
        test_regime();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
